bus_debug_master: RTL



---
 rtl/bus_debug_master_if.sv | 29 ++
 rtl/bus_debug_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bus_debug_master_if.sv
// Host-side byte stream and peripheral bus signals of the debug bus master,
// bundled so the top level can hand them to the block as one port.
interface bus_debug_master_if;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        o_rx_ready;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready;
   logic [15:0] o_bus_addr;
   logic [7:0]  o_bus_data;
   logic        o_bus_cs;
   logic        o_bus_rwb;
   logic [7:0]  i_bus_data;
   logic        i_bus_wait;
   logic        o_busy;

   modport master (
      input  i_rx_data, i_rx_valid, i_tx_ready, i_bus_data, i_bus_wait,
      output o_rx_ready, o_tx_data, o_tx_valid, o_bus_addr, o_bus_data,
             o_bus_cs, o_bus_rwb, o_busy
   );

   modport slave (
      output i_rx_data, i_rx_valid, i_tx_ready, i_bus_data, i_bus_wait,
      input  o_rx_ready, o_tx_data, o_tx_valid, o_bus_addr, o_bus_data,
             o_bus_cs, o_bus_rwb, o_busy
   );
endinterface

// File: rtl/bus_debug_master.sv
// Byte-stream driven bus initiator: parses host read/write commands from the
// UART, runs one peripheral bus access per command and answers ACK/NAK.
module bus_debug_master #(
   parameter int         READ_CYCLES = 2,
   parameter int         WAIT_LIMIT  = 255,
   parameter logic [7:0] ACK         = 8'h06,
   parameter logic [7:0] NAK         = 8'h15
) (
   input logic                clk,
   input logic                resetb,
   bus_debug_master_if.master bus
);
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
   localparam logic [7:0] READ_LAST = 8'(READ_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WDATA, BUS, RESP0, RESP1} state_t;

   state_t      state, state_next;
   logic        is_read, is_read_next;
   logic        access_ok, access_ok_next;
   logic [7:0]  addr_hi, addr_hi_next;
   logic [7:0]  addr_lo, addr_lo_next;
   logic [7:0]  wait_cnt, wait_cnt_next;
   logic [7:0]  good_cnt, good_cnt_next;
   logic [7:0]  rdata, rdata_next;
   logic [7:0]  tx_data, tx_data_next;
   logic        tx_valid, tx_valid_next;
   logic [15:0] bus_addr, bus_addr_next;
   logic [7:0]  bus_data, bus_data_next;
   logic        bus_cs, bus_cs_next;
   logic        bus_rwb, bus_rwb_next;
   logic        busy, busy_next;

   logic rx_ready, rx_fire, tx_fire, cmd_known, bus_done, bus_timeout;

   assign rx_ready    = (state == IDLE) || (state == ADDR_HI) ||
                        (state == ADDR_LO) || (state == WDATA);
   assign rx_fire     = bus.i_rx_valid && rx_ready;
   assign tx_fire     = tx_valid && bus.i_tx_ready;
   assign cmd_known   = (bus.i_rx_data == CMD_WRITE) || (bus.i_rx_data == CMD_READ);
   // A wait-low cycle always completes or progresses the access, so it beats the timeout.
   assign bus_done    = (state == BUS) && !bus.i_bus_wait && (!is_read || good_cnt == READ_LAST);
   assign bus_timeout = (state == BUS) && bus.i_bus_wait && (wait_cnt == WAIT_LAST);

   // State register together with every registered output and datapath field
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state     <= IDLE;
         is_read   <= 1'b0;
         access_ok <= 1'b0;
         addr_hi   <= 8'h00;
         addr_lo   <= 8'h00;
         wait_cnt  <= 8'h00;
         good_cnt  <= 8'h00;
         rdata     <= 8'h00;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         bus_addr  <= 16'h0000;
         bus_data  <= 8'h00;
         bus_cs    <= 1'b0;
         bus_rwb   <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state     <= state_next;
         is_read   <= is_read_next;
         access_ok <= access_ok_next;
         addr_hi   <= addr_hi_next;
         addr_lo   <= addr_lo_next;
         wait_cnt  <= wait_cnt_next;
         good_cnt  <= good_cnt_next;
         rdata     <= rdata_next;
         tx_data   <= tx_data_next;
         tx_valid  <= tx_valid_next;
         bus_addr  <= bus_addr_next;
         bus_data  <= bus_data_next;
         bus_cs    <= bus_cs_next;
         bus_rwb   <= bus_rwb_next;
         busy      <= busy_next;
      end
   end

   // Command parsing, bus access and response sequencing
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rx_fire) state_next = cmd_known ? ADDR_HI : RESP0;
         ADDR_HI: if (rx_fire) state_next = ADDR_LO;
         ADDR_LO: if (rx_fire) state_next = is_read ? BUS : WDATA;
         WDATA:   if (rx_fire) state_next = BUS;
         BUS:     if (bus_done || bus_timeout) state_next = RESP0;
         RESP0:   if (tx_fire) state_next = (is_read && access_ok) ? RESP1 : IDLE;
         RESP1:   if (tx_fire) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs; cs/rwb follow the upcoming state
   always_comb begin
      is_read_next   = is_read;
      access_ok_next = access_ok;
      addr_hi_next   = addr_hi;
      addr_lo_next   = addr_lo;
      wait_cnt_next  = wait_cnt;
      good_cnt_next  = good_cnt;
      rdata_next     = rdata;
      tx_data_next   = tx_data;
      tx_valid_next  = tx_valid;
      bus_addr_next  = bus_addr;
      bus_data_next  = bus_data;
      busy_next      = busy;
      bus_cs_next    = (state_next == BUS);
      bus_rwb_next   = (state_next == BUS) ? is_read : 1'b1;

      case (state)
         IDLE: if (rx_fire) begin
            is_read_next   = (bus.i_rx_data == CMD_READ);
            access_ok_next = 1'b0;
            busy_next      = cmd_known;
            if (!cmd_known) begin
               tx_valid_next = 1'b1;
               tx_data_next  = NAK;
            end
         end
         ADDR_HI: if (rx_fire) addr_hi_next = bus.i_rx_data;
         ADDR_LO: if (rx_fire) begin
            addr_lo_next = bus.i_rx_data;
            if (is_read) bus_addr_next = {addr_hi, bus.i_rx_data};
         end
         WDATA: if (rx_fire) begin
            bus_addr_next = {addr_hi, addr_lo};
            bus_data_next = bus.i_rx_data;
         end
         BUS: begin
            if (bus.i_bus_wait) wait_cnt_next = wait_cnt + 8'd1;
            else                good_cnt_next = good_cnt + 8'd1;
            if (bus_done) begin
               access_ok_next = 1'b1;
               tx_valid_next  = 1'b1;
               tx_data_next   = ACK;
               if (is_read) rdata_next = bus.i_bus_data;
            end
            if (bus_timeout) begin
               tx_valid_next = 1'b1;
               tx_data_next  = NAK;
            end
         end
         RESP0: if (tx_fire) begin
            if (is_read && access_ok) begin
               tx_data_next = rdata;
            end else begin
               tx_valid_next = 1'b0;
               busy_next     = 1'b0;
            end
         end
         RESP1: if (tx_fire) begin
            tx_valid_next = 1'b0;
            busy_next     = 1'b0;
         end
         default: ;
      endcase

      if (state != BUS && state_next == BUS) begin
         wait_cnt_next = 8'h00;
         good_cnt_next = 8'h00;
      end
   end

   assign bus.o_rx_ready = rx_ready;
   assign bus.o_tx_data  = tx_data;
   assign bus.o_tx_valid = tx_valid;
   assign bus.o_bus_addr = bus_addr;
   assign bus.o_bus_data = bus_data;
   assign bus.o_bus_cs   = bus_cs;
   assign bus.o_bus_rwb  = bus_rwb;
   assign bus.o_busy     = busy;
endmodule
